risc_ctrl_pipe: RTL and testbench
=================================

Name: risc_ctrl_pipe

Overview:
Parametrised successor to the single-cycle main decoder. It decodes the ID-stage instruction into a full control word covering R/I/load/store, all six branches, JAL/JALR, LUI/AUIPC, and the ALU-control decode. It carries the control word through ID/EX, EX/MEM and MEM/WB registers with stall and flush, and resolves pc_src in EX.

Parameters:
ALU_CTRL_W, 4, width of the alu_control encoding (minimum 4)
EN_JUMP, 1, 1 = decode JAL/JALR; 0 = these opcodes are illegal
EN_UPPER, 1, 1 = decode LUI/AUIPC; 0 = these opcodes are illegal
EN_ILLEGAL_TRAP, 1, 1 = drive illegal_w; 0 = illegal_w tied 0

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
instr_d  in  32  ID-stage instruction (op[6:0], funct3[14:12], funct7b5[30])
stall_e  in  1  hold the ID/EX control register
flush_e  in  1  replace the ID/EX contents with a bubble
zero_e  in  1  ALU result == 0
lt_e  in  1  signed rs1 < rs2
ltu_e  in  1  unsigned rs1 < rs2
imm_src_d  out  3  immediate select, combinational from instr_d
alu_control_e  out  ALU_CTRL_W  EX ALU operation
alu_src_a_e  out  1  0 = rs1, 1 = PC (AUIPC)
alu_src_b_e  out  1  0 = rs2, 1 = immediate
pc_src_e  out  1  take branch or jump
pc_tgt_sel_e  out  1  0 = PC+imm, 1 = ALU result (JALR)
mem_write_m  out  1  store enable
reg_write_m  out  1  for forwarding
result_src_m  out  2  for forwarding / load-use detection
reg_write_w  out  1  register-file write enable
result_src_w  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate (LUI)
illegal_w  out  1  illegal instruction reached WB

Behaviour:
- Reset (async, rst_n = 0): every E/M/W control register is cleared to 0 (bubble); all registered outputs read 0; pc_src_e = 0.
- imm_src encoding: I 000, S 001, B 010, J 011, U 100. Undefined opcodes give 000.
- ALU encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, SLTU 1001.
- ALU decode rules:
  - Load, store, JAL, JALR, LUI and AUIPC decode to ADD.
  - Branches decode to SUB.
  - R and I-ALU decode by funct3.
  - funct3 = 000 with op = R and funct7b5 = 1 gives SUB; I-type 000 is always ADD.
  - funct3 = 101 with funct7b5 = 1 gives SRA.
- Illegal opcode (including jump/upper opcodes when disabled): control word all zero (no writes, no branch), illegal flag = 1.
- ID/EX register update priority: flush_e (bubble; illegal cleared) > stall_e (hold) > load decode.
- EX to MEM always advances. When stall_e = 1, EX/MEM receives a bubble, so a stalled instruction never issues twice.
- MEM to WB always advances.
- Latency: decode into E is 1 cycle, E to M 1 cycle, M to W 1 cycle.
- pc_src_e is combinational in EX:
  - jump_e OR (branch_e AND cond).
  - cond by the funct3 stored in E: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu. Funct3 values 010 and 011 are illegal for branches.
  - A bubble, or a stalled E, produces pc_src_e = 0.
- pc_tgt_sel_e = 1 only for JALR.
- Simultaneous stall_e and flush_e: flush wins.
- Asserting rst_n mid-pipeline clears all in-flight controls on the same edge, with no partial writes.

Decomposition:
- Shared package risc_pkg holds:
  - opcode constants (LW, SW, R, I, BR, JAL, JALR, LUI, AUIPC);
  - the ALU_*, IMM_*, RES_* encodings;
  - a ctrl_t packed struct: reg_write, result_src, mem_write, branch, jump, jalr, alu_src_a, alu_src_b, alu_control, funct3, illegal.
- One sub-module, risc_ctrl_decode: purely combinational, maps instr_d to ctrl_t and imm_src.
- The top level holds the three pipeline registers and the branch resolution.

Test Plan:
- add x3,x1,x2 (0x002081B3), no stall: cycle+1 alu_control_e = 0000, alu_src_b_e = 0; cycle+3 reg_write_w = 1, result_src_w = 00.
- sub (0x402081B3) then lw x5,8(x1) (0x0080A283):
  - sub gives alu_control_e = 0001.
  - lw gives alu_src_b_e = 1, then result_src_m = 01, then reg_write_w = 1.
- beq x1,x2,+8 (0x00208463) with zero_e = 1 gives pc_src_e = 1; repeat with zero_e = 0 gives 0.
- bne (funct3 001) with zero_e = 0 gives pc_src_e = 1.
- jal x1,16 (0x010000EF): imm_src_d = 011, pc_src_e = 1 (independent of zero_e), result_src_w = 10.
- lui x5,0x12345 (0x123452B7): imm_src_d = 100, result_src_w = 11.
  - With EN_UPPER = 0: all writes 0 and illegal_w = 1 three cycles later.
- Stall and flush:
  - lw in E with stall_e = 1 for 2 cycles: E holds, mem/reg M-stage outputs go 0 for 2 cycles, then lw proceeds exactly once.
  - stall_e and flush_e together: bubble.
  - rst_n low mid-stream: all outputs 0 asynchronously.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared opcode, ALU, immediate and result encodings plus the pipelined control word
// for the RISC control pipeline.
package risc_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [3:0] alu_control;
    logic [2:0] funct3;
    logic       illegal;
  } ctrl_t;

  // R and I-ALU share the funct3 map; only R-type honours funct7b5 for SUB.
  function automatic logic [3:0] alu_decode(logic [2:0] funct3, logic funct7b5, logic is_r);
    logic [3:0] alu;
    case (funct3)
      3'b000:  alu = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu = ALU_SLL;
      3'b010:  alu = ALU_SLT;
      3'b011:  alu = ALU_SLTU;
      3'b100:  alu = ALU_XOR;
      3'b101:  alu = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu = ALU_OR;
      default: alu = ALU_AND;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/risc_ctrl_decode.sv
// Combinational ID-stage decoder: instruction word to control word and immediate select.
module risc_ctrl_decode
  import risc_pkg::*;
#(
  parameter bit EN_JUMP  = 1'b1,
  parameter bit EN_UPPER = 1'b1
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic [2:0]  imm_src_o
);

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;

  assign op       = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign funct7b5 = instr_i[30];

  logic unused_instr;
  assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

  always_comb begin
    ctrl_o    = '0;
    imm_src_o = IMM_I;
    case (op)
      OP_LW: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = RES_MEM;
        ctrl_o.alu_src_b  = 1'b1;
      end
      OP_SW: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src_b = 1'b1;
        imm_src_o        = IMM_S;
      end
      OP_R: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.alu_control = alu_decode(funct3, funct7b5, 1'b1);
      end
      OP_I: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.alu_src_b   = 1'b1;
        ctrl_o.alu_control = alu_decode(funct3, funct7b5, 1'b0);
      end
      OP_BR: begin
        imm_src_o = IMM_B;
        // funct3 01x has no branch meaning
        if (funct3[2:1] == 2'b01) begin
          ctrl_o.illegal = 1'b1;
        end else begin
          ctrl_o.branch      = 1'b1;
          ctrl_o.alu_control = ALU_SUB;
          ctrl_o.funct3      = funct3;
        end
      end
      OP_JAL: begin
        if (EN_JUMP) begin
          ctrl_o.jump       = 1'b1;
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.result_src = RES_PC4;
          imm_src_o         = IMM_J;
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      OP_JALR: begin
        if (EN_JUMP) begin
          ctrl_o.jump       = 1'b1;
          ctrl_o.jalr       = 1'b1;
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.result_src = RES_PC4;
          ctrl_o.alu_src_b  = 1'b1;
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      OP_LUI: begin
        if (EN_UPPER) begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.result_src = RES_IMM;
          ctrl_o.alu_src_b  = 1'b1;
          imm_src_o         = IMM_U;
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      OP_AUIPC: begin
        if (EN_UPPER) begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = 1'b1;
          imm_src_o        = IMM_U;
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/risc_ctrl_pipe.sv
// Control pipeline: decodes in ID, carries the control word through ID/EX, EX/MEM and
// MEM/WB with stall and flush, and resolves pc_src in EX.
module risc_ctrl_pipe
  import risc_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W      = 4,
  parameter bit          EN_JUMP         = 1'b1,
  parameter bit          EN_UPPER        = 1'b1,
  parameter bit          EN_ILLEGAL_TRAP = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr_d,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic                  zero_e,
  input  logic                  lt_e,
  input  logic                  ltu_e,
  output logic [2:0]            imm_src_d,
  output logic [ALU_CTRL_W-1:0] alu_control_e,
  output logic                  alu_src_a_e,
  output logic                  alu_src_b_e,
  output logic                  pc_src_e,
  output logic                  pc_tgt_sel_e,
  output logic                  mem_write_m,
  output logic                  reg_write_m,
  output logic [1:0]            result_src_m,
  output logic                  reg_write_w,
  output logic [1:0]            result_src_w,
  output logic                  illegal_w
);

  ctrl_t ctrl_d;

  risc_ctrl_decode #(
    .EN_JUMP  (EN_JUMP),
    .EN_UPPER (EN_UPPER)
  ) u_decode (
    .instr_i   (instr_d),
    .ctrl_o    (ctrl_d),
    .imm_src_o (imm_src_d)
  );

  ctrl_t      ctrl_e_q, ctrl_e_d;
  logic       reg_write_m_q, mem_write_m_q, illegal_m_q;
  logic [1:0] result_src_m_q;
  logic       reg_write_w_q, illegal_w_q;
  logic [1:0] result_src_w_q;

  always_comb begin
    ctrl_e_d = ctrl_d;
    if (flush_e) begin
      ctrl_e_d = '0;
    end else if (stall_e) begin
      ctrl_e_d = ctrl_e_q;
    end
  end

  // A stalled E hands a bubble to M so the held instruction only issues once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_e_q       <= '0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      illegal_m_q    <= 1'b0;
      result_src_m_q <= RES_ALU;
      reg_write_w_q  <= 1'b0;
      illegal_w_q    <= 1'b0;
      result_src_w_q <= RES_ALU;
    end else begin
      ctrl_e_q       <= ctrl_e_d;
      reg_write_m_q  <= stall_e ? 1'b0 : ctrl_e_q.reg_write;
      mem_write_m_q  <= stall_e ? 1'b0 : ctrl_e_q.mem_write;
      illegal_m_q    <= stall_e ? 1'b0 : ctrl_e_q.illegal;
      result_src_m_q <= stall_e ? RES_ALU : ctrl_e_q.result_src;
      reg_write_w_q  <= reg_write_m_q;
      illegal_w_q    <= illegal_m_q;
      result_src_w_q <= result_src_m_q;
    end
  end

  logic branch_cond;

  always_comb begin
    branch_cond = 1'b0;
    case (ctrl_e_q.funct3)
      3'b000:  branch_cond = zero_e;
      3'b001:  branch_cond = ~zero_e;
      3'b100:  branch_cond = lt_e;
      3'b101:  branch_cond = ~lt_e;
      3'b110:  branch_cond = ltu_e;
      3'b111:  branch_cond = ~ltu_e;
      default: branch_cond = 1'b0;
    endcase
  end

  assign pc_src_e      = ~stall_e & (ctrl_e_q.jump | (ctrl_e_q.branch & branch_cond));
  assign pc_tgt_sel_e  = ctrl_e_q.jalr;
  assign alu_control_e = ALU_CTRL_W'(ctrl_e_q.alu_control);
  assign alu_src_a_e   = ctrl_e_q.alu_src_a;
  assign alu_src_b_e   = ctrl_e_q.alu_src_b;

  assign mem_write_m  = mem_write_m_q;
  assign reg_write_m  = reg_write_m_q;
  assign result_src_m = result_src_m_q;
  assign reg_write_w  = reg_write_w_q;
  assign result_src_w = result_src_w_q;
  assign illegal_w    = EN_ILLEGAL_TRAP ? illegal_w_q : 1'b0;

endmodule

// File: tb/tb_risc_ctrl_pipe.sv
// Scoreboard bench for risc_ctrl_pipe: one full-feature instance and one with jump/upper
// opcodes disabled, both checked against a behavioural model each cycle.
module tb_risc_ctrl_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst_n;
  logic [31:0] instr_d;
  logic        stall_e, flush_e, zero_e, lt_e, ltu_e;

  logic [2:0] imm_a, imm_b;
  logic [3:0] alu_a, alu_b;
  logic       sa_a, sa_b, sb_a, sb_b, pc_a, pc_b, tgt_a, tgt_b;
  logic       mw_m_a, mw_m_b, rw_m_a, rw_m_b, rw_w_a, rw_w_b, ill_a, ill_b;
  logic [1:0] rs_m_a, rs_m_b, rs_w_a, rs_w_b;

  risc_ctrl_pipe u_dut (
    .clk (clk), .rst_n (rst_n), .instr_d (instr_d), .stall_e (stall_e), .flush_e (flush_e),
    .zero_e (zero_e), .lt_e (lt_e), .ltu_e (ltu_e), .imm_src_d (imm_a), .alu_control_e (alu_a),
    .alu_src_a_e (sa_a), .alu_src_b_e (sb_a), .pc_src_e (pc_a), .pc_tgt_sel_e (tgt_a),
    .mem_write_m (mw_m_a), .reg_write_m (rw_m_a), .result_src_m (rs_m_a),
    .reg_write_w (rw_w_a), .result_src_w (rs_w_a), .illegal_w (ill_a)
  );

  risc_ctrl_pipe #(
    .ALU_CTRL_W (4), .EN_JUMP (1'b0), .EN_UPPER (1'b0), .EN_ILLEGAL_TRAP (1'b1)
  ) u_dut_nj (
    .clk (clk), .rst_n (rst_n), .instr_d (instr_d), .stall_e (stall_e), .flush_e (flush_e),
    .zero_e (zero_e), .lt_e (lt_e), .ltu_e (ltu_e), .imm_src_d (imm_b), .alu_control_e (alu_b),
    .alu_src_a_e (sa_b), .alu_src_b_e (sb_b), .pc_src_e (pc_b), .pc_tgt_sel_e (tgt_b),
    .mem_write_m (mw_m_b), .reg_write_m (rw_m_b), .result_src_m (rs_m_b),
    .reg_write_w (rw_w_b), .result_src_w (rs_w_b), .illegal_w (ill_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instruction expectation as the ISA rules describe it.
  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       br;
    logic       jmp;
    logic       jalr;
    logic       a;
    logic       b;
    logic [3:0] alu;
    logic [2:0] f3;
    logic       ill;
  } rec_t;

  typedef struct packed {
    logic [2:0] imm;
    logic [3:0] alu;
    logic       a;
    logic       b;
    logic       pc;
    logic       tgt;
    logic       mw_m;
    logic       rw_m;
    logic [1:0] rs_m;
    logic       rw_w;
    logic [1:0] rs_w;
    logic       ill_w;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } snap_t;

  snap_t sq[$];
  rec_t  me[2], mm[2], mw[2];
  int    n_checks = 0;
  int    n_err = 0;

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input bit is_r);
    case (f3)
      3'd0:    return (is_r && f7) ? 4'd1 : 4'd0;
      3'd1:    return 4'd6;
      3'd2:    return 4'd5;
      3'd3:    return 4'd9;
      3'd4:    return 4'd4;
      3'd5:    return f7 ? 4'd8 : 4'd7;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic void ref_dec(input logic [31:0] ins, input bit en, output rec_t r,
                                  output logic [2:0] imm);
    logic [2:0] f3;
    logic       f7;
    f3  = ins[14:12];
    f7  = ins[30];
    r   = '0;
    imm = 3'd0;
    case (ins[6:0])
      7'b0110011: begin r.rw = 1; r.alu = alu_of(f3, f7, 1'b1); end
      7'b0010011: begin r.rw = 1; r.b = 1; r.alu = alu_of(f3, f7, 1'b0); end
      7'b0000011: begin r.rw = 1; r.rs = 2'd1; r.b = 1; end
      7'b0100011: begin r.mw = 1; r.b = 1; imm = 3'd1; end
      7'b1100011: begin
        imm = 3'd2;
        if (f3 == 3'd2 || f3 == 3'd3) r.ill = 1;
        else begin r.br = 1; r.alu = 4'd1; r.f3 = f3; end
      end
      7'b1101111: if (en) begin r.jmp = 1; r.rw = 1; r.rs = 2'd2; imm = 3'd3; end
                  else r.ill = 1;
      7'b1100111: if (en) begin r.jmp = 1; r.jalr = 1; r.rw = 1; r.rs = 2'd2; r.b = 1; end
                  else r.ill = 1;
      7'b0110111: if (en) begin r.rw = 1; r.rs = 2'd3; r.b = 1; imm = 3'd4; end
                  else r.ill = 1;
      7'b0010111: if (en) begin r.rw = 1; r.a = 1; r.b = 1; imm = 3'd4; end
                  else r.ill = 1;
      default: r.ill = 1;
    endcase
  endfunction

  function automatic bit taken(input rec_t e, input bit st, input bit z, input bit l, input bit lu);
    bit c;
    case (e.f3)
      3'd0: c = z;
      3'd1: c = !z;
      3'd4: c = l;
      3'd5: c = !l;
      3'd6: c = lu;
      3'd7: c = !lu;
      default: c = 0;
    endcase
    return !st && (e.jmp || (e.br && c));
  endfunction

  // Advance the model on a clock edge and queue what both DUTs should show next.
  task automatic model_edge();
    rec_t  r;
    logic [2:0] imm;
    obs_t  o[2];
    snap_t s;
    for (int i = 0; i < 2; i++) begin
      ref_dec(instr_d, (i == 0), r, imm);
      if (!rst_n) begin
        me[i] = '0; mm[i] = '0; mw[i] = '0;
      end else begin
        mw[i] = mm[i];
        mm[i] = stall_e ? rec_t'(0) : me[i];
        if (flush_e) me[i] = '0;
        else if (!stall_e) me[i] = r;
      end
      o[i].imm   = imm;
      o[i].alu   = me[i].alu;
      o[i].a     = me[i].a;
      o[i].b     = me[i].b;
      o[i].pc    = taken(me[i], stall_e, zero_e, lt_e, ltu_e);
      o[i].tgt   = me[i].jalr;
      o[i].mw_m  = mm[i].mw;
      o[i].rw_m  = mm[i].rw;
      o[i].rs_m  = mm[i].rs;
      o[i].rw_w  = mw[i].rw;
      o[i].rs_w  = mw[i].rs;
      o[i].ill_w = mw[i].ill;
    end
    s.a = o[0];
    s.b = o[1];
    sq.push_back(s);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_obs(input string t, input obs_t act, input obs_t exp);
    chk({t, ".imm_src_d"}, int'(act.imm), int'(exp.imm));
    chk({t, ".alu_control_e"}, int'(act.alu), int'(exp.alu));
    chk({t, ".alu_src_a_e"}, int'(act.a), int'(exp.a));
    chk({t, ".alu_src_b_e"}, int'(act.b), int'(exp.b));
    chk({t, ".pc_src_e"}, int'(act.pc), int'(exp.pc));
    chk({t, ".pc_tgt_sel_e"}, int'(act.tgt), int'(exp.tgt));
    chk({t, ".mem_write_m"}, int'(act.mw_m), int'(exp.mw_m));
    chk({t, ".reg_write_m"}, int'(act.rw_m), int'(exp.rw_m));
    chk({t, ".result_src_m"}, int'(act.rs_m), int'(exp.rs_m));
    chk({t, ".reg_write_w"}, int'(act.rw_w), int'(exp.rw_w));
    chk({t, ".result_src_w"}, int'(act.rs_w), int'(exp.rs_w));
    chk({t, ".illegal_w"}, int'(act.ill_w), int'(exp.ill_w));
  endtask

  // Monitor: compares the queued expectation with the DUTs on every falling edge.
  always @(negedge clk) begin
    snap_t s;
    obs_t  oa, ob;
    if (sq.size() > 0) begin
      s  = sq.pop_front();
      oa = {imm_a, alu_a, sa_a, sb_a, pc_a, tgt_a, mw_m_a, rw_m_a, rs_m_a, rw_w_a, rs_w_a, ill_a};
      ob = {imm_b, alu_b, sa_b, sb_b, pc_b, tgt_b, mw_m_b, rw_m_b, rs_m_b, rw_w_b, rs_w_b, ill_b};
      cmp_obs("A", oa, s.a);
      cmp_obs("B", ob, s.b);
    end
  end

  task automatic step(input logic [31:0] ins, input bit st, input bit fl, input bit z,
                      input bit l, input bit lu);
    instr_d = ins;
    stall_e = st;
    flush_e = fl;
    zero_e  = z;
    lt_e    = l;
    ltu_e   = lu;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic async_reset_check();
    rst_n = 1'b0;
    #1;
    chk("async.alu_control_e", int'(alu_a), 0);
    chk("async.alu_src_b_e", int'(sb_a), 0);
    chk("async.pc_src_e", int'(pc_a), 0);
    chk("async.mem_write_m", int'(mw_m_a), 0);
    chk("async.reg_write_m", int'(rw_m_a), 0);
    chk("async.reg_write_w", int'(rw_w_a), 0);
    chk("async.result_src_w", int'(rs_w_a), 0);
    chk("async.illegal_w_nj", int'(ill_b), 0);
    step(NOP, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  logic [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    logic [31:0] rnd;
    logic [6:0]  op;
    int          k;
    rst_n = 1'b0; instr_d = NOP; stall_e = 0; flush_e = 0; zero_e = 0; lt_e = 0; ltu_e = 0;
    for (int i = 0; i < 3; i++) me[i%2] = '0;
    me[1] = '0; mm[0] = '0; mm[1] = '0; mw[0] = '0; mw[1] = '0;
    @(negedge clk);
    #1;
    step(32'h0020_81B3, 0, 0, 0, 0, 0);
    step(NOP, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    step(32'h0020_81B3, 0, 0, 0, 0, 0);   // add
    step(32'h4020_81B3, 0, 0, 0, 0, 0);   // sub
    step(32'h0080_A283, 0, 0, 0, 0, 0);   // lw
    step(32'h0020_8463, 0, 0, 1, 0, 0);   // beq taken
    step(32'h0020_8463, 0, 0, 0, 0, 0);   // beq not taken
    step(32'h0020_9463, 0, 0, 0, 0, 0);   // bne taken
    step(32'h0100_00EF, 0, 0, 1, 0, 0);   // jal
    step(32'h1234_52B7, 0, 0, 0, 0, 0);   // lui
    step(32'h0080_A283, 0, 0, 0, 0, 0);   // lw, then held in E
    step(NOP, 1, 0, 0, 0, 0);
    step(NOP, 1, 0, 0, 0, 0);
    step(NOP, 0, 0, 0, 0, 0);
    step(32'h0080_A283, 0, 0, 0, 0, 0);
    step(NOP, 1, 1, 0, 0, 0);             // stall + flush
    for (int i = 0; i < 4; i++) step(NOP, 0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      rnd = $urandom();
      k   = $urandom_range(0, 9);
      op  = (k == 9) ? rnd[6:0] : ops[k];
      if (i == 300) async_reset_check();
      step({rnd[31:7], op}, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
           rnd[7], rnd[8], rnd[9]);
    end
    for (int i = 0; i < 4; i++) step(NOP, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
